byte_chan_reader: RTL and testbench

BYTE_CHAN_READER -- requirements
Module: byte_chan_reader

---
 rtl/byte_chan_pkg.sv | 8 +
 rtl/byte_chan.sv | 12 +
 rtl/byte_fifo.sv | 77 +++++++
 rtl/byte_chan_reader.sv | 75 +++++++
 tb/tb_byte_chan_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_chan_pkg.sv
// Shared byte type and width for the byte channel and its reader.
package byte_chan_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned BYTE_W = $bits(byte_t);

endpackage

// File: rtl/byte_chan.sv
// Byte channel: writer offers x/valid, reader answers with ready.
interface byte_chan;
    import byte_chan_pkg::*;

    byte_t x;
    logic  valid;
    logic  ready;

    modport writer (output x, output valid, input ready);
    modport reader (input x, input valid, output ready);

endinterface

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO; storage, pointers and occupancy.
module byte_fifo
    import byte_chan_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  head_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    byte_t             mem_q [DEPTH];
    byte_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Storage is qualified by pointers and level only, so it carries no reset.
    always_comb begin
        mem_d = mem_q;
        if (push && !clear) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

endmodule

// File: rtl/byte_chan_reader.sv
// Accepts bytes from a byte channel into a FIFO and keeps a running count and XOR checksum.
module byte_chan_reader
    import byte_chan_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    byte_chan.reader               chan,
    input  logic                   clear,
    output byte_t                  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       count,
    output byte_t                  checksum,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [LVL_W-1:0] level_w;
    logic             ready_c;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_q, count_d;
    byte_t            checksum_q, checksum_d;

    // Ready is held low through reset so nothing is accepted while state is forced.
    assign ready_c    = rst_n && (level_w != LVL_W'(DEPTH)) && !clear;
    assign chan.ready = ready_c;
    assign push       = chan.valid && ready_c;
    assign out_valid  = (level_w != '0);
    assign pop        = out_valid && out_ready;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (chan.x),
        .pop       (pop),
        .head_data (out_data),
        .level     (level_w)
    );

    always_comb begin
        count_d    = count_q;
        checksum_d = checksum_q;
        if (clear) begin
            count_d    = '0;
            checksum_d = '0;
        end else if (push) begin
            count_d    = count_q + CNT_W'(1);
            checksum_d = checksum_q ^ chan.x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            checksum_q <= '0;
        end else begin
            count_q    <= count_d;
            checksum_q <= checksum_d;
        end
    end

    assign count    = count_q;
    assign checksum = checksum_q;
    assign level    = level_w;

endmodule

// File: tb/tb_byte_chan_reader.sv
// Directed bench for byte_chan_reader with a queue-based reference model checked every cycle.
module tb_byte_chan_reader;
    import byte_chan_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             clear = 1'b0;
    logic             out_ready = 1'b0;
    byte_t            out_data;
    logic             out_valid;
    logic [CNT_W-1:0] count;
    byte_t            checksum;
    logic [LVL_W-1:0] level;

    int n_cmp = 0;
    int n_fail = 0;

    byte_chan bch();

    byte_chan_reader #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chan      (bch),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .checksum  (checksum),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored bytes plus running count and XOR.
    byte_t mq[$];
    int    m_cnt = 0;
    int    m_ck = 0;
    bit    m_push;
    bit    m_pop;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_cnt = 0;
                m_ck  = 0;
            end else begin
                m_push = bch.valid && (mq.size() != DEPTH) && !clear;
                m_pop  = (mq.size() != 0) && out_ready;
                if (clear) begin
                    mq.delete();
                    m_cnt = 0;
                    m_ck  = 0;
                end else begin
                    if (m_pop) begin
                        void'(mq.pop_front());
                    end
                    if (m_push) begin
                        mq.push_back(bch.x);
                        m_cnt = (m_cnt + 1) % (1 << CNT_W);
                        m_ck  = m_ck ^ int'(bch.x);
                    end
                end
            end
        end
    end

    // Compare on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("ready", 32'(bch.ready), 32'(rst_n && (mq.size() != DEPTH) && !clear));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("level", 32'(level), 32'(mq.size()));
            chk("count", 32'(count), 32'(m_cnt));
            chk("checksum", 32'(checksum), 32'(m_ck));
            if (mq.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(mq[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input byte_t d, input logic ordy, input logic clr);
        bch.valid = v;
        bch.x     = d;
        out_ready = ordy;
        clear     = clr;
    endtask

    initial begin
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(bch.ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bch.ready), 32'd1);

        // Three bytes streamed straight through.
        tick();
        set_in(1'b1, 8'h11, 1'b1, 1'b0);
        tick();
        chk("s1_valid", 32'(out_valid), 32'd1);
        chk("s1_data", 32'(out_data), 32'h11);
        bch.x = 8'h22;
        tick();
        chk("s2_data", 32'(out_data), 32'h22);
        bch.x = 8'h33;
        tick();
        chk("s3_data", 32'(out_data), 32'h33);
        bch.valid = 1'b0;
        tick();
        chk("s_empty", 32'(out_valid), 32'd0);
        chk("s_count", 32'(count), 32'd3);
        chk("s_checksum", 32'(checksum), 32'h00);

        // Fill to full with the sink stalled, then free one slot.
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        chk("clr_count", 32'(count), 32'd0);
        clear = 1'b0;
        bch.valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bch.x = byte_t'(i);
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(bch.ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_checksum", 32'(checksum), 32'h04);
        bch.x = 8'h05;
        tick();
        chk("held_level", 32'(level), 32'd4);
        chk("held_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        tick();
        chk("pop_level", 32'(level), 32'd3);
        chk("pop_head", 32'(out_data), 32'h02);
        chk("pop_ready", 32'(bch.ready), 32'd1);
        out_ready = 1'b0;
        tick();
        chk("fifth_level", 32'(level), 32'd4);
        chk("fifth_count", 32'(count), 32'd5);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("drain_03", 32'(out_data), 32'h03);
        tick();
        chk("drain_04", 32'(out_data), 32'h04);
        tick();
        chk("drain_05", 32'(out_data), 32'h05);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Push and pop together at level 3.
        set_in(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        bch.x = 8'hA2;
        tick();
        bch.x = 8'hA3;
        tick();
        chk("pp_pre_level", 32'(level), 32'd3);
        set_in(1'b1, 8'hA5, 1'b1, 1'b0);
        tick();
        chk("pp_level", 32'(level), 32'd3);
        chk("pp_head_a2", 32'(out_data), 32'hA2);
        bch.valid = 1'b0;
        tick();
        chk("pp_head_a3", 32'(out_data), 32'hA3);
        tick();
        chk("pp_head_a5", 32'(out_data), 32'hA5);
        tick();
        chk("pp_empty", 32'(out_valid), 32'd0);

        // Clear with a byte on offer at level 2.
        set_in(1'b1, 8'hC1, 1'b0, 1'b0);
        tick();
        bch.x = 8'hC2;
        tick();
        chk("cl_pre_level", 32'(level), 32'd2);
        set_in(1'b1, 8'h77, 1'b0, 1'b1);
        #1;
        chk("cl_ready", 32'(bch.ready), 32'd0);
        tick();
        chk("cl_level", 32'(level), 32'd0);
        chk("cl_count", 32'(count), 32'd0);
        chk("cl_checksum", 32'(checksum), 32'd0);
        chk("cl_out_valid", 32'(out_valid), 32'd0);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("cl_after_level", 32'(level), 32'd0);

        // Asynchronous reset in the middle of a cycle with three bytes stored.
        set_in(1'b1, 8'hD1, 1'b0, 1'b0);
        tick();
        bch.x = 8'hD2;
        tick();
        bch.x = 8'hD3;
        tick();
        chk("ar_pre_level", 32'(level), 32'd3);
        bch.valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(bch.ready), 32'd0);
        chk("ar_level", 32'(level), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("ar_after_valid2", 32'(out_valid), 32'd0);
        chk("ar_after_count", 32'(count), 32'd0);

        // Run the counter up to its top value, then wrap it.
        set_in(1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            bch.x = byte_t'(i);
            tick();
        end
        chk("wrap_pre_count", 32'(count), 32'hFFFF);
        chk("wrap_pre_checksum", 32'(checksum), 32'hFF);
        bch.x = 8'h5A;
        tick();
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_checksum", 32'(checksum), 32'hA5);
        chk("wrap_head", 32'(out_data), 32'h5A);
        bch.valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
